// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and width helpers for the CPU instruction cache.
//               Holds the cache FSM state encoding and the tag/line-count
//               expressions used by the cache, its tag RAM and the bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Default geometry: 16-bit instructions, 1K-word space, 16 lines.
  localparam int unsigned c_DEF_WIDTH       = 16;
  localparam int unsigned c_DEF_IADDR_WIDTH = 10;
  localparam int unsigned c_DEF_INDEX_WIDTH = 4;

  // Cache controller states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } icache_state_e;

  // One word per line, so the tag is everything above the index.
  function automatic int unsigned tag_width(input int unsigned iaddr_w,
                                            input int unsigned index_w);
    return iaddr_w - index_w;
  endfunction

  function automatic int unsigned line_count(input int unsigned index_w);
    return 32'd1 << index_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_tagram.sv
// ============================================================================
// Module      : icache_tagram
// Description : Tag + valid array for the direct-mapped instruction cache.
//               Valid bits reset asynchronously and clear in one cycle on
//               flush; tags are plain storage. A combinational compare
//               reports whether the read index holds a valid matching tag.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               i_flush          - clear every valid bit at the next edge
//               i_rd_idx/i_rd_tag- lookup index and tag
//               o_match          - valid & tag equal at i_rd_idx
//               i_wr_en/idx/tag  - line fill
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_tagram
  import cpu_pkg::*;
#(
  parameter int unsigned IADDR_WIDTH = c_DEF_IADDR_WIDTH,
  parameter int unsigned INDEX_WIDTH = c_DEF_INDEX_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          i_flush,
  input  logic [INDEX_WIDTH-1:0]                        i_rd_idx,
  input  logic [tag_width(IADDR_WIDTH,INDEX_WIDTH)-1:0] i_rd_tag,
  output logic                                          o_match,
  input  logic                                          i_wr_en,
  input  logic [INDEX_WIDTH-1:0]                        i_wr_idx,
  input  logic [tag_width(IADDR_WIDTH,INDEX_WIDTH)-1:0] i_wr_tag
);

  localparam int unsigned c_TAG_W = tag_width(IADDR_WIDTH, INDEX_WIDTH);
  localparam int unsigned c_LINES = line_count(INDEX_WIDTH);

  logic [c_TAG_W-1:0] r_tag [c_LINES];
  logic [c_LINES-1:0] r_valid;

  // Flush takes priority over a fill in the same cycle: the fill still
  // lands in the tag array but the line is left invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_match = r_valid[i_rd_idx] & (r_tag[i_rd_idx] == i_rd_tag);

endmodule

`default_nettype wire

// File: rtl/cpu_icache.sv
// ============================================================================
// Module      : cpu_icache
// Description : Direct-mapped, one-word-per-line instruction cache. Gives the
//               core synchronous-ROM timing on a hit (address in N, data in
//               N+1), stalls on a miss and refills over a req/ack port.
// Ports       : clk, reset (async, active-low)
//               iaddr/idata/stall - core fetch port
//               flush             - one-cycle whole-cache invalidate
//               mem_req/mem_addr/mem_ack/mem_rdata - refill port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_icache
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH       = c_DEF_WIDTH,
  parameter int unsigned IADDR_WIDTH = c_DEF_IADDR_WIDTH,
  parameter int unsigned INDEX_WIDTH = c_DEF_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IADDR_WIDTH-1:0] iaddr,
  output logic [WIDTH-1:0]       idata,
  output logic                   stall,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [IADDR_WIDTH-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [WIDTH-1:0]       mem_rdata
);

  localparam int unsigned c_TAG_W = tag_width(IADDR_WIDTH, INDEX_WIDTH);
  localparam int unsigned c_LINES = line_count(INDEX_WIDTH);

  icache_state_e          r_state;
  icache_state_e          w_state_nxt;
  logic [IADDR_WIDTH-1:0] r_addr_q;
  logic                   r_look_v;
  logic [IADDR_WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0]       r_data [c_LINES];

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [c_TAG_W-1:0]     w_tag;
  logic                   w_match;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_fill;
  logic                   w_req;

  assign w_idx  = r_addr_q[INDEX_WIDTH-1:0];
  assign w_tag  = r_addr_q[IADDR_WIDTH-1:INDEX_WIDTH];
  assign w_hit  = r_look_v & w_match;
  assign w_miss = r_look_v & ~w_match;

  // Stall depends on registers only, so mem_ack never reaches the core's
  // fetch-enable path combinationally.
  assign stall  = (r_state != ST_IDLE) | w_miss;

  icache_tagram #(
    .IADDR_WIDTH (IADDR_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_tagram (
    .clk      (clk),
    .rst_n    (reset),
    .i_flush  (flush),
    .i_rd_idx (w_idx),
    .i_rd_tag (w_tag),
    .o_match  (w_match),
    .i_wr_en  (w_fill),
    .i_wr_idx (w_idx),
    .i_wr_tag (w_tag)
  );

  // Lookup register: frozen while stalled so the refill target and the
  // replay lookup both use the address that missed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_q <= '0;
      r_look_v <= 1'b0;
    end else if (!stall) begin
      r_addr_q <= iaddr;
      r_look_v <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_req = 1'b1;
        if (mem_ack) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Refill address is captured on the miss and held for the whole request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr <= '0;
    end else if ((r_state == ST_IDLE) && w_miss) begin
      r_mem_addr <= r_addr_q;
    end
  end

  // Data array kept without reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_rdata;
    end
  end

  assign idata    = w_hit ? r_data[w_idx] : '0;
  assign mem_req  = w_req;
  assign mem_addr = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_cpu_icache.sv
// ============================================================================
// Module      : tb_cpu_icache
// Description : Self-checking bench for cpu_icache. A behavioural memory
//               answers refill requests after a programmable latency; every
//               accepted fetch pushes its expected instruction into a queue
//               that is popped when the cache delivers the word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_icache;
  import cpu_pkg::*;

  localparam int unsigned c_W  = 16;
  localparam int unsigned c_AW = 10;

  logic            clk;
  logic            reset;
  logic [c_AW-1:0] iaddr;
  logic [c_W-1:0]  idata;
  logic            stall;
  logic            flush_main;
  logic            flush_resp;
  logic            mem_req;
  logic [c_AW-1:0] mem_addr;
  logic            mem_ack;
  logic [c_W-1:0]  mem_rdata;
  wire             flush = flush_main | flush_resp;

  int total = 0;
  int bad   = 0;

  logic [c_W-1:0]  mem_img [1024];
  logic [c_W-1:0]  exp_q [$];

  int              lat = 3;
  int              req_run = 0;
  int              ack_cnt = 0;
  int              last_req_cycles = 0;
  logic [c_AW-1:0] last_ack_addr = '0;
  logic            flush_on_ack = 1'b0;

  cpu_icache #(
    .WIDTH       (c_W),
    .IADDR_WIDTH (c_AW),
    .INDEX_WIDTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iaddr     (iaddr),
    .idata     (idata),
    .stall     (stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: answers after 'lat' request cycles, optionally pulsing
  // flush in the same cycle as the ack.
  initial begin
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    flush_resp = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack    = 1'b0;
      flush_resp = 1'b0;
      if (mem_req) begin
        req_run++;
        if (req_run >= lat) begin
          mem_ack         = 1'b1;
          mem_rdata       = mem_img[mem_addr];
          last_ack_addr   = mem_addr;
          last_req_cycles = req_run;
          ack_cnt++;
          req_run         = 0;
          if (flush_on_ack) begin
            flush_resp   = 1'b1;
            flush_on_ack = 1'b0;
          end
        end
      end else begin
        req_run = 0;
      end
    end
  end

  // Called at the negedge after an accepting edge: counts stalled cycles,
  // then pops the expected word and compares it with idata.
  task automatic wait_result(input string tag, input int exp_stall);
    int n;
    logic [c_W-1:0] e;
    n = 0;
    while (stall && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (n >= 64) check_val({tag, "_timeout"}, 32'(n), 32'd0);
    check_val({tag, "_stall"}, 32'(n), 32'(exp_stall));
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_idata"}, 32'(idata), 32'(e));
    end
  endtask

  // Must be entered just after a negedge with stall low.
  task automatic fetch(input string tag, input logic [c_AW-1:0] a, input int exp_stall);
    iaddr = a;
    exp_q.push_back(mem_img[a]);
    @(negedge clk);
    wait_result(tag, exp_stall);
  endtask

  initial begin
    int acks0;
    int n;
    for (int i = 0; i < 1024; i++) mem_img[i] = 16'(i * 37) ^ 16'h5A00;
    mem_img[10'h005] = 16'h1234;
    mem_img[10'h015] = 16'hBEEF;

    reset      = 1'b0;
    iaddr      = '0;
    flush_main = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_stall",   32'(stall),    32'd0);
    check_val("rst_idata",   32'(idata),    32'd0);
    check_val("rst_mem_req", 32'(mem_req),  32'd0);
    check_val("rst_mem_addr",32'(mem_addr), 32'd0);
    reset = 1'b1;

    // Cold miss with a 3-cycle memory.
    acks0 = ack_cnt;
    fetch("cold", 10'h005, 4);
    check_val("cold_req_cyc", 32'(last_req_cycles), 32'd3);
    check_val("cold_memaddr", 32'(last_ack_addr),   32'h005);
    check_val("cold_acks",    32'(ack_cnt - acks0), 32'd1);

    // Hit: no stall, no memory traffic.
    acks0 = ack_cnt;
    fetch("hit", 10'h005, 0);
    check_val("hit_acks", 32'(ack_cnt - acks0), 32'd0);

    // Conflict on index 5.
    fetch("conf_a", 10'h015, 4);
    check_val("conf_a_addr", 32'(last_ack_addr), 32'h015);
    fetch("conf_b", 10'h005, 4);
    check_val("conf_b_addr", 32'(last_ack_addr), 32'h005);

    // Hit delivered in the flush cycle; the following lookup misses.
    iaddr = 10'h005;
    exp_q.push_back(mem_img[10'h005]);
    @(negedge clk);
    flush_main = 1'b1;
    exp_q.push_back(mem_img[10'h005]);
    wait_result("flush_hit", 0);
    @(negedge clk);
    flush_main = 1'b0;
    wait_result("post_flush", 4);

    // Flush coinciding with the ack: fill stays invalid, refetch follows.
    acks0 = ack_cnt;
    flush_on_ack = 1'b1;
    fetch("flush_fetch", 10'h020, 8);
    check_val("flush_fetch_acks", 32'(ack_cnt - acks0), 32'd2);
    fetch("flush_fetch_hit", 10'h020, 0);

    // A few misses then hits across distinct indices.
    for (int i = 0; i < 4; i++) fetch("sweep_miss", 10'(10'h131 + i), 4);
    for (int i = 0; i < 4; i++) fetch("sweep_hit",  10'(10'h131 + i), 0);

    // Reset in the middle of a refill.
    lat   = 10;
    iaddr = 10'h077;
    @(negedge clk);
    n = 0;
    while (!mem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_val("midrst_req_seen", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("midrst_mem_req", 32'(mem_req),  32'd0);
    check_val("midrst_stall",   32'(stall),    32'd0);
    check_val("midrst_idata",   32'(idata),    32'd0);
    check_val("midrst_memaddr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    lat   = 3;
    acks0 = ack_cnt;
    fetch("after_rst", 10'h077, 4);
    check_val("after_rst_acks", 32'(ack_cnt - acks0), 32'd1);
    fetch("after_rst_old", 10'h131, 4);

    // Zero-latency ack.
    lat = 1;
    fetch("zero_lat", 10'h100, 2);
    check_val("zero_lat_req_cyc", 32'(last_req_cycles), 32'd1);

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/cpu_icache.md
Name: cpu_icache

Overview:
Direct-mapped instruction cache between the CPU instruction port (iaddr/idata) and a slower, handshaked instruction memory.
- Presents the same synchronous-ROM timing the core expects on a hit: address in cycle N, data in cycle N+1.
- Asserts stall on a miss and refills the line through a req/ack port.
- Supports a one-cycle whole-cache invalidate (flush) for self-modifying or reloaded program images.

Parameters:
WIDTH, 16, instruction word width
IADDR_WIDTH, 10, instruction address width (word addressed)
INDEX_WIDTH, 4, log2 of line count; one word per line; tag width = IADDR_WIDTH-INDEX_WIDTH

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
iaddr  in  IADDR_WIDTH  fetch address from core, sampled when stall=0
idata  out  WIDTH  instruction for address sampled on previous edge; valid when stall=0
stall  out  1  core must hold IP; iaddr ignored while high
flush  in  1  invalidate all lines (single-cycle pulse)
mem_req  out  1  refill request, held until mem_ack
mem_addr  out  IADDR_WIDTH  refill address, stable while mem_req=1
mem_ack  in  1  one-cycle pulse: mem_rdata valid, request done
mem_rdata  in  WIDTH  refill data

Behaviour:
- Storage: data[2^INDEX_WIDTH] x WIDTH, tag[2^INDEX_WIDTH] x tag width, valid[2^INDEX_WIDTH] x 1. Index = iaddr[INDEX_WIDTH-1:0]; tag = upper bits.
- Registered lookup: when stall=0, addr_q <= iaddr and look_v <= 1. look_v is cleared by reset, so there is no lookup in the first cycle after reset.
- hit = look_v & valid[idx(addr_q)] & (tag[idx(addr_q)] == tag(addr_q)). miss = look_v & ~hit.
- idata = data[idx(addr_q)] on hit; 0 otherwise.
- stall = (state != IDLE) | miss. This is combinational from registers only; no path from mem_ack to stall.
- FSM states:
  - IDLE: on miss, go to FETCH and drive mem_addr <= addr_q.
  - FETCH: mem_req=1, mem_addr stable. On mem_ack, write data/tag of idx(addr_q) from mem_rdata, set valid unless flush is high in the same cycle, then go to IDLE.
  - IDLE after fill: the replay lookup of the frozen addr_q hits, and stall drops.
- Miss penalty: stall is high from the miss-detect cycle through the ack cycle. idata is valid one cycle after mem_ack. Zero-latency ack (ack in the first FETCH cycle) gives 2 stall cycles.
- addr_q and look_v are frozen while stall=1. The core is never required to hold iaddr.
- flush:
  - Clears all valid bits at the next edge.
  - A hit in the flush cycle is still delivered, because lookup uses pre-flush state.
  - Flush during FETCH: the request completes; the fill is written but stays invalid; the replay misses and refetches.
  - Flush together with mem_ack: flush wins.
- mem_ack while in IDLE is ignored.
- Reset (asynchronous, any time, including mid-FETCH):
  - state=IDLE, valid all 0, look_v=0, addr_q=0.
  - mem_req=0, mem_addr=0, stall=0, idata=0.
  - The memory side must tolerate an abandoned request.
- Data/tag arrays are not reset.

Decomposition:
- Shared package cpu_pkg: icache state enum (IDLE, FETCH) and the tag/index width expressions, shared with cpu and testbench.
- One natural sub-module, icache_tagram: tag+valid array with flush-clear and a combinational compare returning hit.
- Data array stays inline so it can infer block RAM.

Test Plan:
- Cold miss: release reset, iaddr=0x005, memory acks after 3 cycles with 0x1234 -> mem_req high 3 cycles with mem_addr=0x005; stall high 4 cycles; then idata=0x1234, stall=0.
- Hit: refetch 0x005 after a fill -> stall=0, idata=0x1234 one cycle after iaddr; mem_req stays 0.
- Conflict: fill 0x005, then fetch 0x015 (same index, memory returns 0xBEEF), then 0x005 -> second fetch misses and returns 0xBEEF; third misses again and refetches 0x1234.
- Flush during FETCH: miss on 0x020, pulse flush in the ack cycle -> replay misses; a second request is issued for 0x020; valid only after the second ack.
- Reset mid-FETCH: assert reset with mem_req=1 -> mem_req and stall drop immediately (asynchronous); after release, a fetch of the same address misses.
- Zero-latency ack: ack in the first FETCH cycle -> stall high exactly 2 cycles.
